// File: rtl/conversor_bcd_produto.sv
// -----------------------------------------------------------------------------
// conversor_bcd_produto
//
// Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
// Takes the 8-bit product of the 4x4 array multiplier and produces three
// BCD digits (hundreds, tens, units) for the display stage.
//
// One conversion is 1 accept edge + 8 SHIFT cycles + 1 DONE cycle:
//   - start sampled high in IDLE at the edge ending cycle N
//   - busy = 1 in cycles N+1 .. N+8
//   - done = 1 and new digits visible in cycle N+9
//   - IDLE again in cycle N+10 (one conversion per 10 cycles)
// The digit outputs hold their last value between conversions, so the
// display can read them at any time.
//
// Ports:
//   clk    in   1  rising-edge system clock
//   reset  in   1  synchronous, active-high reset (priority over start)
//   start  in   1  conversion request, only looked at in IDLE
//   bin    in   8  unsigned value to convert, captured on the accepting edge
//   busy   out  1  high while the 8 shift steps are running
//   done   out  1  one-cycle pulse, digits updated in this same cycle
//   bcd_c  out  4  hundreds digit (0..2)
//   bcd_d  out  4  tens digit     (0..9)
//   bcd_u  out  4  units digit    (0..9)
// -----------------------------------------------------------------------------
module conversor_bcd_produto (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       busy,
   output logic       done,
   output logic [3:0] bcd_c,
   output logic [3:0] bcd_d,
   output logic [3:0] bcd_u
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Number of shift steps equals the input width; the counter wraps to 0
   // on the last step, so it is naturally ready for the next conversion.
   localparam logic [2:0] LAST_SHIFT = 3'd7;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t      state_q, state_d;
   // Layout: [19:16] hundreds, [15:12] tens, [11:8] units, [7:0] binary input.
   logic [19:0] sr_q, sr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  bcd_c_q, bcd_c_d;
   logic [3:0]  bcd_d_q, bcd_d_d;
   logic [3:0]  bcd_u_q, bcd_u_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // ---------------------------------------------------------------------------
   // Datapath: one double-dabble step
   // ---------------------------------------------------------------------------
   // A nibble of 5..9 becomes 8..12, so the following left shift carries a
   // decimal ten into the next nibble. Nibbles never exceed 9 before the
   // adjust, so the 4-bit add cannot overflow.
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   logic [19:0] sr_adj;
   logic [19:0] sr_shift;

   // All three nibble checks look at the pre-shift register, in parallel.
   assign sr_adj = {add3(sr_q[19:16]),
                    add3(sr_q[15:12]),
                    add3(sr_q[11:8]),
                    sr_q[7:0]};

   // The hundreds nibble stays <= 2, so nothing meaningful leaves bit 19.
   assign sr_shift = sr_adj << 1;

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of the block so that no
   // path through the case leaves it unassigned; otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bcd_c_d = bcd_c_q;
      bcd_d_d = bcd_d_q;
      bcd_u_d = bcd_u_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               sr_d    = {12'd0, bin};
               cnt_d   = 3'd0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST_SHIFT) begin
               // Digits are taken from the value after the 8th shift, so
               // they land in the output registers exactly for DONE.
               bcd_c_d = sr_shift[19:16];
               bcd_d_d = sr_shift[15:12];
               bcd_u_d = sr_shift[11:8];
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // start is ignored here; the next request is seen in IDLE.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // busy/done are decoded from the next state and registered, so they line
   // up with the state they describe and have no path from the inputs.
   always_comb begin
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // Aborts any conversion in progress without a done pulse.
         state_q <= ST_IDLE;
         sr_q    <= 20'd0;
         cnt_q   <= 3'd0;
         bcd_c_q <= 4'd0;
         bcd_d_q <= 4'd0;
         bcd_u_q <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bcd_c_q <= bcd_c_d;
         bcd_d_q <= bcd_d_d;
         bcd_u_q <= bcd_u_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign busy  = busy_q;
   assign done  = done_q;
   assign bcd_c = bcd_c_q;
   assign bcd_d = bcd_d_q;
   assign bcd_u = bcd_u_q;

endmodule

// File: tb/tb_conversor_bcd_produto.sv
// -----------------------------------------------------------------------------
// tb_conversor_bcd_produto
//
// Directed bench for the binary-to-BCD converter: a vector table of
// {bin, expected digits} plus hand-written sequences for reset, ignored
// start requests, continuous start and a sweep of all 256 inputs.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_conversor_bcd_produto;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] bin;
   logic       busy;
   logic       done;
   logic [3:0] bcd_c;
   logic [3:0] bcd_d;
   logic [3:0] bcd_u;

   int total = 0;
   int bad   = 0;

   conversor_bcd_produto dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd_c (bcd_c),
      .bcd_d (bcd_d),
      .bcd_u (bcd_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int bin;
      int c;
      int d;
      int u;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Starts a conversion from IDLE and follows it to the cycle after done.
   // Leaves the DUT in IDLE (cycle N+10) with start low.
   task automatic run_conv(input int v, input int ec, input int ed, input int eu,
                           input bit full);
      int lat;
      int busy_cycles;
      start = 1'b1;
      bin   = 8'(v);
      tick();                       // cycle N+1
      start = 1'b0;
      bin   = 8'(~v);               // must not affect the running conversion
      lat         = 1;
      busy_cycles = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cycles++;
         tick();
         lat++;
      end
      check($sformatf("latency bin=%0d", v), lat, 9);
      check($sformatf("bcd_c bin=%0d", v), int'(bcd_c), ec);
      check($sformatf("bcd_d bin=%0d", v), int'(bcd_d), ed);
      check($sformatf("bcd_u bin=%0d", v), int'(bcd_u), eu);
      if (full) begin
         check($sformatf("busy_cycles bin=%0d", v), busy_cycles, 8);
         check($sformatf("busy_in_done bin=%0d", v), int'(busy), 0);
      end
      tick();                       // cycle N+10, back in IDLE
      if (full) begin
         check($sformatf("done_one_cycle bin=%0d", v), int'(done), 0);
         check($sformatf("hold_c bin=%0d", v), int'(bcd_c), ec);
         check($sformatf("hold_d bin=%0d", v), int'(bcd_d), ed);
         check($sformatf("hold_u bin=%0d", v), int'(bcd_u), eu);
      end
   endtask

   initial begin
      int ndone;
      int last;
      int sc, sd, su;

      vecs[0] = '{bin:   0, c: 0, d: 0, u: 0};
      vecs[1] = '{bin: 255, c: 2, d: 5, u: 5};
      vecs[2] = '{bin: 225, c: 2, d: 2, u: 5};
      vecs[3] = '{bin:  81, c: 0, d: 8, u: 1};
      vecs[4] = '{bin: 100, c: 1, d: 0, u: 0};
      vecs[5] = '{bin:   9, c: 0, d: 0, u: 9};
      vecs[6] = '{bin:  10, c: 0, d: 1, u: 0};
      vecs[7] = '{bin:  99, c: 0, d: 9, u: 9};
      vecs[8] = '{bin: 199, c: 1, d: 9, u: 9};

      reset = 1'b1;
      start = 1'b0;
      bin   = 8'd0;
      tick();
      tick();

      // Reset values.
      check("rst_busy",  int'(busy),  0);
      check("rst_done",  int'(done),  0);
      check("rst_bcd_c", int'(bcd_c), 0);
      check("rst_bcd_d", int'(bcd_d), 0);
      check("rst_bcd_u", int'(bcd_u), 0);

      // Reset has priority over start at the same edge.
      start = 1'b1;
      bin   = 8'd200;
      tick();
      check("rst_prio_busy", int'(busy), 0);
      reset = 1'b0;
      start = 1'b0;
      tick();
      check("rst_prio_idle", int'(busy), 0);

      // Table-driven conversions.
      for (int i = 0; i < 9; i++) begin
         run_conv(vecs[i].bin, vecs[i].c, vecs[i].d, vecs[i].u, 1'b1);
      end

      // start during SHIFT is ignored: one done, result of the first value.
      start = 1'b1;
      bin   = 8'd42;
      tick();                       // N+1
      start = 1'b0;
      bin   = 8'd0;
      tick();                       // N+2
      tick();                       // N+3
      start = 1'b1;
      bin   = 8'd199;
      tick();
      start = 1'b0;
      ndone = 0;
      sc = 15; sd = 15; su = 15;
      for (int i = 0; i < 25; i++) begin
         if (done) begin
            ndone++;
            sc = int'(bcd_c);
            sd = int'(bcd_d);
            su = int'(bcd_u);
         end
         tick();
      end
      check("ign_done_count", ndone, 1);
      check("ign_bcd_c", sc, 0);
      check("ign_bcd_d", sd, 4);
      check("ign_bcd_u", su, 2);
      check("ign_hold_c", int'(bcd_c), 0);
      check("ign_hold_d", int'(bcd_d), 4);
      check("ign_hold_u", int'(bcd_u), 2);
      check("ign_idle_busy", int'(busy), 0);

      // Reset in the 4th SHIFT cycle aborts the conversion.
      start = 1'b1;
      bin   = 8'd255;
      tick();                       // SHIFT 1
      start = 1'b0;
      tick();                       // SHIFT 2
      tick();                       // SHIFT 3
      tick();                       // SHIFT 4
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy",  int'(busy),  0);
      check("abort_done",  int'(done),  0);
      check("abort_bcd_c", int'(bcd_c), 0);
      check("abort_bcd_d", int'(bcd_d), 0);
      check("abort_bcd_u", int'(bcd_u), 0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         tick();
      end
      check("abort_no_done", ndone, 0);
      run_conv(7, 0, 0, 7, 1'b1);

      // start held high: one conversion every 10 cycles.
      start = 1'b1;
      bin   = 8'd63;
      ndone = 0;
      last  = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done) begin
            ndone++;
            check("cont_bcd_c", int'(bcd_c), 0);
            check("cont_bcd_d", int'(bcd_d), 6);
            check("cont_bcd_u", int'(bcd_u), 3);
            check("cont_busy_done", int'(busy), 0);
            if (last >= 0) check("cont_period", i - last, 10);
            last = i;
         end
      end
      start = 1'b0;
      check("cont_done_count", ndone, 4);
      check("cont_first_done", last - 30, 9);
      tick();

      // Sweep of every input value, back to back.
      for (int v = 0; v < 256; v++) begin
         run_conv(v, v / 100, (v / 10) % 10, v % 10, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
